// File: rtl/booth2_pkg.sv
// Shared widths and types for the Booth-2 16x16 multiplier datapath
// (partial-product compressor and final carry-propagate adder).
package booth2_pkg;

  localparam int PP_WIDTH  = 32;
  localparam int ADD_SPLIT = 16;

  typedef logic [PP_WIDTH-1:0] pp_t;

  localparam pp_t ZERO_PROD = '0;

endpackage

// File: rtl/booth2_pipe_stage.sv
// Generic one-entry valid/ready register slice; data loads only when the slice loads.
module booth2_pipe_stage #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data
);

  // Transfer on valid && ready; accepts when empty or draining this cycle.
  assign in_ready = !out_valid || out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (in_valid && in_ready) begin
      out_valid <= 1'b1;
      out_data  <= in_data;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/booth2_final_adder.sv
// Two-stage split carry-propagate adder: low SPLIT bits in stage 1, high bits plus carry in stage 2.
// Optional out_zero flag enabled by defining BOOTH2_FINAL_ADDER_ZERO_FLAG_EN.
module booth2_final_adder
  import booth2_pkg::*;
#(
  parameter int WIDTH = PP_WIDTH,
  parameter int SPLIT = ADD_SPLIT
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_pp1,
  input  logic [WIDTH-1:0] in_pp2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_prod
`ifdef BOOTH2_FINAL_ADDER_ZERO_FLAG_EN
  ,
  output logic             out_zero
`endif
);

  localparam int HI_W = WIDTH - SPLIT;
  // Stage 1 word: {hi1, hi2, lo_cout, lo_sum}
  localparam int S1_W = 2 * HI_W + 1 + SPLIT;
`ifdef BOOTH2_FINAL_ADDER_ZERO_FLAG_EN
  localparam int S2_W = WIDTH + 1;
`else
  localparam int S2_W = WIDTH;
`endif

  logic [SPLIT:0]     lo_add;
  logic [S1_W-1:0]    s1_in;
  logic [S1_W-1:0]    s1_data;
  logic               s1_valid;
  logic               s2_ready;

  logic [HI_W-1:0]    s1_hi1;
  logic [HI_W-1:0]    s1_hi2;
  logic               s1_cout;
  logic [SPLIT-1:0]   s1_lo_sum;
  logic [HI_W-1:0]    hi_sum;
  logic [WIDTH-1:0]   prod;
  logic [S2_W-1:0]    s2_in;
  logic [S2_W-1:0]    s2_data;

  assign lo_add = {1'b0, in_pp1[SPLIT-1:0]} + {1'b0, in_pp2[SPLIT-1:0]};
  assign s1_in  = {in_pp1[WIDTH-1:SPLIT], in_pp2[WIDTH-1:SPLIT], lo_add};

  booth2_pipe_stage #(
    .DW(S1_W)
  ) u_stage1 (
    .clk      (sys_clk),
    .rst_n    (sys_rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (s1_in),
    .out_valid(s1_valid),
    .out_ready(s2_ready),
    .out_data (s1_data)
  );

  assign s1_hi1    = s1_data[S1_W-1 -: HI_W];
  assign s1_hi2    = s1_data[SPLIT+1 +: HI_W];
  assign s1_cout   = s1_data[SPLIT];
  assign s1_lo_sum = s1_data[SPLIT-1:0];

  // Carry out of the top bit is dropped: the product is modulo 2^WIDTH.
  assign hi_sum = s1_hi1 + s1_hi2 + HI_W'(s1_cout);
  assign prod   = {hi_sum, s1_lo_sum};

`ifdef BOOTH2_FINAL_ADDER_ZERO_FLAG_EN
  assign s2_in    = {(prod == '0), prod};
  assign out_prod = s2_data[WIDTH-1:0];
  assign out_zero = s2_data[WIDTH];
`else
  assign s2_in    = prod;
  assign out_prod = s2_data;
`endif

  booth2_pipe_stage #(
    .DW(S2_W)
  ) u_stage2 (
    .clk      (sys_clk),
    .rst_n    (sys_rst_n),
    .in_valid (s1_valid),
    .in_ready (s2_ready),
    .in_data  (s2_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (s2_data)
  );

endmodule

// File: doc/booth2_final_adder.md
Name: booth2_final_adder

Overview:
- Carry-propagate stage directly downstream of the Booth-2 partial-product compressor; consumes its two compressed 32-bit partial products and produces the final 32-bit signed product of the 16x16 multiplier.
- Two-stage pipelined split adder with valid/ready handshake at both ends.
- Sustains one product per cycle with full backpressure support.

Parameters:
- WIDTH, 32, width of each partial product and of the product.
- SPLIT, 16, number of low bits added in stage 1; the remaining WIDTH-SPLIT bits are added in stage 2. Legal range is 1..WIDTH-1.

Ports:
- sys_clk  input  1  clock; all state updates on the rising edge.
- sys_rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  in_pp1/in_pp2 hold a valid pair.
- in_ready  output  1  block accepts the pair this cycle.
- in_pp1  input  WIDTH  compressed partial product 1 (sum row).
- in_pp2  input  WIDTH  compressed partial product 2 (carry row, already shifted and zero-padded).
- out_valid  output  1  out_prod holds a valid product.
- out_ready  input  1  consumer accepts out_prod this cycle.
- out_prod  output  WIDTH  (in_pp1 + in_pp2) mod 2^WIDTH.

Behaviour:
- Reset (asynchronous, sys_rst_n low): s1_valid=0, s2_valid=0, out_valid=0, out_prod=0, and all stage data registers are 0. in_ready is 1 after reset because the pipeline is empty.
- Handshake: a transfer occurs when valid and ready are both 1 in the same cycle. Once out_valid=1, out_valid and out_prod stay stable until out_ready=1.
- Stage 1 registers, on an accepted input:
  - lo_sum = in_pp1[SPLIT-1:0] + in_pp2[SPLIT-1:0], a SPLIT-bit result.
  - lo_cout, the carry out of that addition.
  - hi1 = in_pp1[WIDTH-1:SPLIT] and hi2 = in_pp2[WIDTH-1:SPLIT], unmodified.
- Stage 2 registers hi_sum = hi1 + hi2 + lo_cout (carry out discarded). out_prod = {hi_sum, lo_sum}.
- Elastic control:
  - s2_ready = !s2_valid || out_ready.
  - s1_ready = !s1_valid || s2_ready.
  - in_ready = s1_ready, which is purely combinational from state and out_ready.
  - Stage 2 loads when s1_valid && s2_ready. Stage 1 loads when in_valid && s1_ready.
  - Each valid bit: set on load; cleared when the stage drains without a new load. Simultaneous drain and load keep the bit at 1.
- Latency: a pair accepted in cycle N is presented with out_valid=1 in cycle N+2 when there is no backpressure.
- Throughput: one product per cycle while out_ready=1.
- Capacity: 2 entries. When both stages are full and out_ready=0, in_ready=0 and the stage registers hold.
- Ordering: strictly in order; no product is dropped or duplicated.
- Overflow: arithmetic is modulo 2^WIDTH. The discarded carry out of the top bit is intended behaviour and is never flagged.
- Data registers load only when their stage loads. Data seen while a valid bit is 0 is don't-care for checking.
- Reset asserted mid-operation: every in-flight product is discarded and out_valid drops asynchronously. After release, the first product appears no earlier than 2 cycles after the first accepted input.

Optional Feature:
- Macro: BOOTH2_FINAL_ADDER_ZERO_FLAG_EN.
- Defined:
  - Adds output out_zero (1 bit), registered alongside out_prod in stage 2.
  - out_zero = 1 when the registered product is all zeros.
  - Reset value 0. Held stable under backpressure exactly like out_prod.
- Undefined: the port and its logic do not exist. All other behaviour is identical.

Decomposition:
- Shared package booth2_pkg holds:
  - constants PP_WIDTH=32 and ADD_SPLIT=16;
  - typedef pp_t (logic [PP_WIDTH-1:0]);
  - the zero-product constant.
  This block and the compressor both use these widths.
- One sub-module, booth2_pipe_stage: a generic valid/ready register slice with a data width parameter, instantiated twice. Its data path is the stage's adder result.

Test Plan:
1. Carry across the split: in_pp1=0x0000FFFF, in_pp2=0x00000001, out_ready=1 -> out_prod=0x00010000 exactly 2 cycles after acceptance.
2. Wrap-around: 0xFFFFFFFF + 0x00000001 -> out_prod=0x00000000, with out_zero=1 when the macro is defined. Signed case: 0xFFFF8000 + 0x00000000 -> 0xFFFF8000.
3. Back-to-back throughput: 8 consecutive pairs (k, 3k) for k=1..8 with out_ready=1 -> out_valid high for 8 consecutive cycles, out_prod = 4, 8, ..., 32 in order.
4. Backpressure: out_ready=0 while 3 pairs are offered -> 2 accepted, then in_ready=0, and out_prod is stable at the first result. Raising out_ready drains all 3 results in order with no loss.
5. Reset mid-operation: 2 pairs in flight, then assert sys_rst_n=0 for 1 cycle -> out_valid=0 and out_prod=0 immediately, in_ready=1 after release, and no stale product emerges.
6. Random sweep: 10k random 16x16 signed operand pairs passed through the compressor model and this block, with random out_ready -> every out_prod equals the signed product a*b.
